// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg                                                              |
// | Shared AHB-lite encodings and master FSM state type.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] c_hresp_okay  = 2'b00;
  localparam logic [1:0] c_hresp_error = 2'b01;
  localparam logic [1:0] c_hresp_retry = 2'b10;
  localparam logic [1:0] c_hresp_split = 2'b11;

  localparam logic [2:0] c_hsize_byte = 3'b000;
  localparam logic [2:0] c_hsize_half = 3'b001;
  localparam logic [2:0] c_hsize_word = 3'b010;

  localparam logic [2:0] c_hburst_single = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } mst_state_t;

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

  // Sizes above a word are not supported on this bus; narrower sizes must be naturally aligned.
  function automatic logic req_is_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b1;
    if (size > c_hsize_word) begin
      ok = 1'b0;
    end else if (size == c_hsize_half && addr_lo[0]) begin
      ok = 1'b0;
    end else if (size == c_hsize_word && addr_lo != 2'b00) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_master_if                                                   |
// | Request/response handshake plus AHB-lite master bus signals.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ahb_lite_master_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [HADDR_WIDTH-1:0] req_addr_i;
  logic                   req_write_i;
  logic [2:0]             req_size_i;
  logic [HDATA_WIDTH-1:0] req_wdata_i;

  logic                   rsp_valid_o;
  logic [HDATA_WIDTH-1:0] rsp_rdata_o;
  logic                   rsp_err_o;
  logic                   rsp_timeout_o;

  logic                   hsel_o;
  logic [HADDR_WIDTH-1:0] haddr_o;
  logic                   hwrite_o;
  logic [1:0]             htrans_o;
  logic [2:0]             hsize_o;
  logic [2:0]             hburst_o;
  logic [3:0]             hprot_o;
  logic                   hmastlock_o;
  logic [HDATA_WIDTH-1:0] hwdata_o;

  logic                   hready_i;
  logic [1:0]             hresp_i;
  logic [HDATA_WIDTH-1:0] hrdata_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
    input  hready_i, hresp_i, hrdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hprot_o,
    output hmastlock_o, hwdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
    output hready_i, hresp_i, hrdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hprot_o,
    input  hmastlock_o, hwdata_o
  );

endinterface
`default_nettype wire

// File: rtl/ahb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_timeout_cnt                                                      |
// | Saturating data-phase wait counter with expiry flag.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_timeout_cnt
  import ahb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               c_cnt_w = cnt_width(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(TIMEOUT);
  localparam bit               c_en    = (TIMEOUT != 0);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && r_cnt != c_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With TIMEOUT of zero the counter is pinned at zero and never reports expiry.
  assign expired_o = c_en && (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_master                                                      |
// | Single-outstanding AHB-lite master: one request -> one SINGLE xfer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int         HADDR_WIDTH = 32,
  parameter int         HDATA_WIDTH = 32,
  parameter int         TIMEOUT     = 256,
  parameter logic [3:0] HPROT       = 4'b0011
) (
  input logic               clk_i,
  input logic               rst_i,
  ahb_lite_master_if.master bus
);

  mst_state_t             r_state, w_state;
  logic                   r_illegal, w_illegal;
  logic [HDATA_WIDTH-1:0] r_wdata, w_wdata;
  logic                   r_req_ready, w_req_ready;
  logic                   r_rsp_valid, w_rsp_valid;
  logic [HDATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic                   r_rsp_err, w_rsp_err;
  logic                   r_rsp_timeout, w_rsp_timeout;
  logic                   r_hsel, w_hsel;
  logic [HADDR_WIDTH-1:0] r_haddr, w_haddr;
  logic                   r_hwrite, w_hwrite;
  htrans_t                r_htrans, w_htrans;
  logic [2:0]             r_hsize, w_hsize;
  logic [HDATA_WIDTH-1:0] r_hwdata, w_hwdata;
  logic                   w_legal;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic                   w_expired;

  assign w_legal = req_is_legal(bus.req_size_i, bus.req_addr_i[1:0]);

  ahb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_cnt_clr),
    .en_i      (w_cnt_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_illegal     <= 1'b0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_hsel        <= 1'b0;
      r_haddr       <= '0;
      r_hwrite      <= 1'b0;
      r_htrans      <= HTRANS_IDLE;
      r_hsize       <= '0;
      r_hwdata      <= '0;
    end else begin
      r_state       <= w_state;
      r_illegal     <= w_illegal;
      r_wdata       <= w_wdata;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
      r_hsel        <= w_hsel;
      r_haddr       <= w_haddr;
      r_hwrite      <= w_hwrite;
      r_htrans      <= w_htrans;
      r_hsize       <= w_hsize;
      r_hwdata      <= w_hwdata;
    end
  end

  // Every output is computed here one cycle ahead and registered above.
  always_comb begin
    w_state       = r_state;
    w_illegal     = r_illegal;
    w_wdata       = r_wdata;
    w_req_ready   = 1'b0;
    w_rsp_valid   = 1'b0;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_err     = r_rsp_err;
    w_rsp_timeout = r_rsp_timeout;
    w_hsel        = r_hsel;
    w_haddr       = r_haddr;
    w_hwrite      = r_hwrite;
    w_htrans      = r_htrans;
    w_hsize       = r_hsize;
    w_hwdata      = r_hwdata;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid_i && r_req_ready) begin
          w_req_ready = 1'b0;
          w_state     = ST_ADDR;
          w_wdata     = bus.req_wdata_i;
          w_illegal   = !w_legal;
          if (w_legal) begin
            w_hsel   = 1'b1;
            w_htrans = HTRANS_NONSEQ;
            w_haddr  = bus.req_addr_i;
            w_hwrite = bus.req_write_i;
            w_hsize  = bus.req_size_i;
          end
        end
      end
      ST_ADDR: begin
        // Rejected requests idle the bus for this cycle so the response lands one cycle after accept.
        if (r_illegal) begin
          w_state       = ST_RESP;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b0;
        end else if (bus.hready_i) begin
          w_state   = ST_DATA;
          w_hsel    = 1'b0;
          w_htrans  = HTRANS_IDLE;
          w_hwdata  = r_wdata;
          w_cnt_clr = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.hready_i) begin
          w_state       = ST_RESP;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = (bus.hresp_i != c_hresp_okay);
          w_rsp_timeout = 1'b0;
          w_hwdata      = '0;
          if (!r_hwrite) begin
            w_rsp_rdata = bus.hrdata_i;
          end
        end else if (w_expired) begin
          w_state       = ST_RESP;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
          w_hwdata      = '0;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        w_state     = ST_IDLE;
        w_req_ready = 1'b1;
      end
      default: begin
        w_state     = ST_IDLE;
        w_req_ready = 1'b1;
      end
    endcase
  end

  assign bus.req_ready_o   = r_req_ready;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_rdata_o   = r_rsp_rdata;
  assign bus.rsp_err_o     = r_rsp_err;
  assign bus.rsp_timeout_o = r_rsp_timeout;
  assign bus.hsel_o        = r_hsel;
  assign bus.haddr_o       = r_haddr;
  assign bus.hwrite_o      = r_hwrite;
  assign bus.htrans_o      = r_htrans;
  assign bus.hsize_o       = r_hsize;
  assign bus.hburst_o      = c_hburst_single;
  assign bus.hprot_o       = HPROT;
  assign bus.hmastlock_o   = 1'b0;
  assign bus.hwdata_o      = r_hwdata;

endmodule
`default_nettype wire
